replica_exchange_unit: RTL and testbench
========================================

// Module: replica_exchange_unit
// PURPOSE
//  Per-replica exchange decision unit, successor of the fixed odd/even exchange latch.
//  Pairs replicas (lower=leader, upper=follower) by parity and runs a pipelined Metropolis test.
//  The test is (dE*dBeta + ln_r >= 0). The result goes to the neighbour over a valid/accept link.
//  Issues exchange_command_t (replica_pkg: NOP/SELF/PREV/FOLW) to the exchange and metropolis paths.
// PARAMETERS
//  ID            0   replica index, 0..REPLICA_NUM-1
//  REPLICA_NUM   32  total replicas; 1 => always SELF
//  EW            32  signed energy width
//  BW            16  signed inverse-temperature (beta) width
//  PARITY_AUTO   0   0: parity from parity_in; 1: internal parity toggles every accepted start
// PORTS
//  clk           in   1        clock
//  reset         in   1        async active-high reset
//  start         in   1        one-cycle request to begin an exchange round
//  parity_in     in   1        0: pairs (2k,2k+1); 1: pairs (2k+1,2k+2)
//  e_self        in   EW       own energy, sampled on accepted start
//  e_folw        in   EW       follower (ID+1) energy, sampled on accepted start
//  b_self        in   BW       own beta, sampled on accepted start
//  b_folw        in   BW       follower beta, sampled on accepted start
//  ln_r          in   EW+BW    signed log-uniform random (<=0), sampled on accepted start
//  shift_d       in   1        ordering read/write: forces exchange_ex=PREV, exchange_mtr unaffected
//  prev_valid    in   1        leader (ID-1) result strobe
//  prev_accept   in   1        leader (ID-1) test result
//  out_valid     out  1        own result strobe to follower (leader role only)
//  out_accept    out  1        own test result
//  exchange_ex   out  2        command for exchange path
//  exchange_mtr  out  2        command for metropolis path
//  busy          out  1        round in progress
//  done          out  1        one-cycle pulse: command valid
//  start_err     out  1        sticky: start seen while busy; cleared only by reset
//  accept_cnt    out  32       accepted exchanges (STAT feature)
//  trial_cnt     out  32       tests performed (STAT feature)
// BEHAVIOUR
//  Reset: exchange_ex=exchange_mtr=NOP; out_valid=out_accept=busy=done=start_err=0; cnt=0.
//  Reset: internal parity=0; FSM=IDLE. Reset mid-round aborts, no done.
//  Role at accepted start, with p = PARITY_AUTO ? internal : parity_in:
//   - LEADER: (ID%2)==p and ID+1<REPLICA_NUM
//   - FOLLOWER: (ID%2)!=p and ID>0
//   - else ALONE (ends, REPLICA_NUM=1)
//  FSM IDLE->(start) S1->S2->S3->IDLE for LEADER; IDLE->WAIT->IDLE for FOLLOWER; IDLE->DONE for ALONE.
//   - S1: dE=e_self-e_folw, dB=b_self-b_folw, each sign-extended 1 bit.
//   - S2: prod=dE*dB, full EW+BW+2 bits signed.
//   - S3: acc=(prod+sext(ln_r))>=0. out_accept=acc, out_valid=1 for 1 cycle.
//     cmd=acc?FOLW:SELF; done=1.
//   - LEADER latency: done 3 cycles after start (start@T, done@T+3).
//   - WAIT: on prev_valid, cmd=prev_accept?PREV:SELF, done=1. No timeout; start ignored.
//   - ALONE: cmd=SELF, done 1 cycle after start.
//  exchange_mtr=cmd; exchange_ex=shift_d?PREV:cmd (combinational on shift_d).
//  cmd holds its value until the next accepted start, where it goes to NOP until done.
//  out_accept holds until the next accepted start.
//  busy=1 from cycle after start until the done cycle inclusive.
//  start while busy: dropped, start_err set; start in the same cycle as done is accepted.
//  PARITY_AUTO=1: parity toggles on each accepted start, after role is computed.
//  prev_valid outside WAIT: ignored.
// CONFIGURATION
//  REPLICA_EXCHANGE_STAT_EN defined:
//   - trial_cnt +1 at each LEADER S3.
//   - accept_cnt +1 when acc=1 there.
//   - both saturate at 32'hFFFF_FFFF.
//  Undefined: accept_cnt=trial_cnt=0 constant; no counter flops.
// TESTING
//  T1 ID=2,p=0:
//   - e_self=10,e_folw=4,b_self=3,b_folw=1,ln_r=0 -> prod=12.
//   - done@T+3, out_accept=1, exchange_mtr=FOLW.
//  T2 ID=2,p=0:
//   - e_self=4,e_folw=10,b=3/1,ln_r=-11 -> prod=-12, sum=-23.
//   - exchange_mtr=SELF; then ln_r=0 with prod=0 -> FOLW.
//  T3 ID=3,p=0, follower:
//   - prev_valid pulse 5 cycles after start with prev_accept=1 -> done that cycle, PREV.
//   - start while waiting -> start_err=1.
//  T4 ID=0,p=1 and ID=31,p=1 (REPLICA_NUM=32):
//   - SELF, done@T+1.
//   - shift_d=1 -> exchange_ex=PREV while exchange_mtr=SELF.
//  T5 PARITY_AUTO=1, ID=4:
//   - rounds alternate LEADER/FOLLOWER.
//   - reset asserted at S2 -> all outputs reset values, no done.
//  T6 REPLICA_EXCHANGE_STAT_EN, 10 leader rounds, 7 accepted -> trial_cnt=10, accept_cnt=7.
//   - Undefined build: both 0.

Source files
------------

// File: rtl/replica_exchange_unit.sv
// Replica exchange decision unit: parity pairing plus a pipelined Metropolis test.
// Define REPLICA_EXCHANGE_STAT_EN to build the saturating trial/accept counters.
module replica_exchange_unit #(
  parameter int ID          = 0,
  parameter int REPLICA_NUM = 32,
  parameter int EW          = 32,
  parameter int BW          = 16,
  parameter int PARITY_AUTO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              parity_in,
  input  logic [EW-1:0]     e_self,
  input  logic [EW-1:0]     e_folw,
  input  logic [BW-1:0]     b_self,
  input  logic [BW-1:0]     b_folw,
  input  logic [EW+BW-1:0]  ln_r,
  input  logic              shift_d,
  input  logic              prev_valid,
  input  logic              prev_accept,
  output logic              out_valid,
  output logic              out_accept,
  output logic [1:0]        exchange_ex,
  output logic [1:0]        exchange_mtr,
  output logic              busy,
  output logic              done,
  output logic              start_err,
  output logic [31:0]       accept_cnt,
  output logic [31:0]       trial_cnt
);

  localparam logic [1:0] CMD_NOP  = 2'd0;
  localparam logic [1:0] CMD_SELF = 2'd1;
  localparam logic [1:0] CMD_PREV = 2'd2;
  localparam logic [1:0] CMD_FOLW = 2'd3;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_S1   = 3'd1;
  localparam logic [2:0] ST_S2   = 3'd2;
  localparam logic [2:0] ST_S3   = 3'd3;
  localparam logic [2:0] ST_WAIT = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  localparam logic ID_ODD   = (ID % 2) == 1;
  localparam logic CAN_LEAD = (ID + 1) < REPLICA_NUM;
  localparam logic CAN_FOLW = ID > 0;
  localparam int   PW       = EW + BW + 2;
  localparam int   SW       = PW + 1;

  logic [2:0]           r_state;
  logic                 r_parity;
  logic signed [EW:0]   r_de;
  logic signed [BW:0]   r_db;
  logic signed [PW-1:0] r_prod;
  logic [EW+BW-1:0]     r_ln;
  logic [1:0]           r_cmd;
  logic                 r_accept;
  logic                 r_start_err;

  logic                 w_p;
  logic                 w_leader;
  logic                 w_follower;
  logic                 w_prev_done;
  logic                 w_done;
  logic                 w_start_acc;
  logic [SW-1:0]        w_sum;
  logic                 w_acc;
  logic [1:0]           w_cmd;

  assign w_p         = (PARITY_AUTO != 0) ? r_parity : parity_in;
  assign w_leader    = (ID_ODD == w_p) && CAN_LEAD;
  assign w_follower  = (ID_ODD != w_p) && CAN_FOLW;
  assign w_prev_done = (r_state == ST_WAIT) && prev_valid;
  assign w_done      = (r_state == ST_S3) || (r_state == ST_DONE) || w_prev_done;
  // A start coinciding with the done cycle chains straight into the next round.
  assign w_start_acc = start && ((r_state == ST_IDLE) || w_done);

  // One guard bit above the product keeps the ln_r addition from wrapping.
  assign w_sum = {r_prod[PW-1], r_prod} + {{(SW-EW-BW){r_ln[EW+BW-1]}}, r_ln};
  assign w_acc = ~w_sum[SW-1];

  // The follower decision is visible in the same cycle the leader strobe arrives.
  assign w_cmd = w_prev_done ? (prev_accept ? CMD_PREV : CMD_SELF) : r_cmd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_parity    <= 1'b0;
      r_de        <= '0;
      r_db        <= '0;
      r_prod      <= '0;
      r_ln        <= '0;
      r_cmd       <= CMD_NOP;
      r_accept    <= 1'b0;
      r_start_err <= 1'b0;
    end else begin
      if (start && !w_start_acc) r_start_err <= 1'b1;
      if (w_start_acc) begin
        r_accept <= 1'b0;
        r_de     <= {e_self[EW-1], e_self} - {e_folw[EW-1], e_folw};
        r_db     <= {b_self[BW-1], b_self} - {b_folw[BW-1], b_folw};
        r_ln     <= ln_r;
        if (PARITY_AUTO != 0) r_parity <= ~r_parity;
        if (w_leader) begin
          r_state <= ST_S1;
          r_cmd   <= CMD_NOP;
        end else if (w_follower) begin
          r_state <= ST_WAIT;
          r_cmd   <= CMD_NOP;
        end else begin
          r_state <= ST_DONE;
          r_cmd   <= CMD_SELF;
        end
      end else begin
        case (r_state)
          ST_S1: begin
            r_prod  <= PW'(r_de) * PW'(r_db);
            r_state <= ST_S2;
          end
          ST_S2: begin
            r_accept <= w_acc;
            r_cmd    <= w_acc ? CMD_FOLW : CMD_SELF;
            r_state  <= ST_S3;
          end
          ST_WAIT: begin
            if (prev_valid) begin
              r_cmd   <= w_cmd;
              r_state <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef REPLICA_EXCHANGE_STAT_EN
  logic [31:0] r_trial_cnt;
  logic [31:0] r_accept_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_trial_cnt  <= '0;
      r_accept_cnt <= '0;
    end else if (r_state == ST_S2) begin
      if (r_trial_cnt != 32'hFFFF_FFFF) r_trial_cnt <= r_trial_cnt + 32'd1;
      if (w_acc && (r_accept_cnt != 32'hFFFF_FFFF)) r_accept_cnt <= r_accept_cnt + 32'd1;
    end
  end

  assign trial_cnt  = r_trial_cnt;
  assign accept_cnt = r_accept_cnt;
`else
  assign trial_cnt  = 32'd0;
  assign accept_cnt = 32'd0;
`endif

  assign exchange_mtr = w_cmd;
  assign exchange_ex  = shift_d ? CMD_PREV : w_cmd;
  assign out_valid    = (r_state == ST_S3);
  assign out_accept   = r_accept;
  assign busy         = (r_state != ST_IDLE);
  assign done         = w_done;
  assign start_err    = r_start_err;

endmodule

// File: tb/tb_replica_exchange_unit.sv
// Directed bench for replica_exchange_unit: leader, follower, edge replicas and auto parity.
module tb_replica_exchange_unit;

  localparam logic [31:0] NOP  = 32'd0;
  localparam logic [31:0] SELF = 32'd1;
  localparam logic [31:0] PREV = 32'd2;
  localparam logic [31:0] FOLW = 32'd3;

`ifdef REPLICA_EXCHANGE_STAT_EN
  localparam logic [31:0] EXP_TRIAL  = 32'd10;
  localparam logic [31:0] EXP_ACCEPT = 32'd7;
`else
  localparam logic [31:0] EXP_TRIAL  = 32'd0;
  localparam logic [31:0] EXP_ACCEPT = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst, rst4;
  logic        start2, start3, start_e, start4;
  logic        parity_in, shift_d, pv, pa;
  logic [31:0] e_self, e_folw;
  logic [15:0] b_self, b_folw;
  logic [47:0] ln_r;

  // index 0: ID=2, 1: ID=3, 2: ID=0, 3: ID=31, 4: ID=4 with auto parity
  logic        ov[5], oa[5], bsy[5], dn[5], serr[5];
  logic [1:0]  ex[5], mtr[5];
  logic [31:0] acnt[5], tcnt[5];

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  replica_exchange_unit #(.ID(2)) u2 (
    .clk(clk), .reset(rst), .start(start2), .parity_in(parity_in),
    .e_self(e_self), .e_folw(e_folw), .b_self(b_self), .b_folw(b_folw), .ln_r(ln_r),
    .shift_d(shift_d), .prev_valid(pv), .prev_accept(pa),
    .out_valid(ov[0]), .out_accept(oa[0]), .exchange_ex(ex[0]), .exchange_mtr(mtr[0]),
    .busy(bsy[0]), .done(dn[0]), .start_err(serr[0]), .accept_cnt(acnt[0]), .trial_cnt(tcnt[0]));

  replica_exchange_unit #(.ID(3)) u3 (
    .clk(clk), .reset(rst), .start(start3), .parity_in(parity_in),
    .e_self(e_self), .e_folw(e_folw), .b_self(b_self), .b_folw(b_folw), .ln_r(ln_r),
    .shift_d(shift_d), .prev_valid(pv), .prev_accept(pa),
    .out_valid(ov[1]), .out_accept(oa[1]), .exchange_ex(ex[1]), .exchange_mtr(mtr[1]),
    .busy(bsy[1]), .done(dn[1]), .start_err(serr[1]), .accept_cnt(acnt[1]), .trial_cnt(tcnt[1]));

  replica_exchange_unit #(.ID(0)) u0 (
    .clk(clk), .reset(rst), .start(start_e), .parity_in(parity_in),
    .e_self(e_self), .e_folw(e_folw), .b_self(b_self), .b_folw(b_folw), .ln_r(ln_r),
    .shift_d(shift_d), .prev_valid(pv), .prev_accept(pa),
    .out_valid(ov[2]), .out_accept(oa[2]), .exchange_ex(ex[2]), .exchange_mtr(mtr[2]),
    .busy(bsy[2]), .done(dn[2]), .start_err(serr[2]), .accept_cnt(acnt[2]), .trial_cnt(tcnt[2]));

  replica_exchange_unit #(.ID(31)) u31 (
    .clk(clk), .reset(rst), .start(start_e), .parity_in(parity_in),
    .e_self(e_self), .e_folw(e_folw), .b_self(b_self), .b_folw(b_folw), .ln_r(ln_r),
    .shift_d(shift_d), .prev_valid(pv), .prev_accept(pa),
    .out_valid(ov[3]), .out_accept(oa[3]), .exchange_ex(ex[3]), .exchange_mtr(mtr[3]),
    .busy(bsy[3]), .done(dn[3]), .start_err(serr[3]), .accept_cnt(acnt[3]), .trial_cnt(tcnt[3]));

  replica_exchange_unit #(.ID(4), .PARITY_AUTO(1)) u4 (
    .clk(clk), .reset(rst4), .start(start4), .parity_in(parity_in),
    .e_self(e_self), .e_folw(e_folw), .b_self(b_self), .b_folw(b_folw), .ln_r(ln_r),
    .shift_d(shift_d), .prev_valid(pv), .prev_accept(pa),
    .out_valid(ov[4]), .out_accept(oa[4]), .exchange_ex(ex[4]), .exchange_mtr(mtr[4]),
    .busy(bsy[4]), .done(dn[4]), .start_err(serr[4]), .accept_cnt(acnt[4]), .trial_cnt(tcnt[4]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input logic [31:0] es, input logic [31:0] ef,
                          input logic [15:0] bs, input logic [15:0] bf, input logic [47:0] ln);
    e_self = es; e_folw = ef; b_self = bs; b_folw = bf; ln_r = ln;
  endtask

  // Full leader round on ID=2; inputs are scrambled after start to prove sampling.
  task automatic lead2(input string tag, input logic [31:0] es, input logic [31:0] ef,
                       input logic [15:0] bs, input logic [15:0] bf, input logic [47:0] ln,
                       input logic acc);
    logic [31:0] cmd;
    cmd = acc ? FOLW : SELF;
    set_data(es, ef, bs, bf, ln);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    set_data(32'h1234_5678, 32'h7FFF_0000, 16'h8001, 16'h7FFF, 48'h8000_0000_0000);
    chk({tag, "_busy1"}, 32'(bsy[0]), 32'd1);
    chk({tag, "_nop"}, 32'(mtr[0]), NOP);
    chk({tag, "_done1"}, 32'(dn[0]), 32'd0);
    tick();
    chk({tag, "_done2"}, 32'(dn[0]), 32'd0);
    tick();
    chk({tag, "_done3"}, 32'(dn[0]), 32'd1);
    chk({tag, "_ovalid"}, 32'(ov[0]), 32'd1);
    chk({tag, "_oacc"}, 32'(oa[0]), 32'(acc));
    chk({tag, "_mtr"}, 32'(mtr[0]), cmd);
    tick();
    chk({tag, "_done4"}, 32'(dn[0]), 32'd0);
    chk({tag, "_idle"}, 32'(bsy[0]), 32'd0);
    chk({tag, "_hold"}, 32'(mtr[0]), cmd);
  endtask

  initial begin
    rst = 1'b1; rst4 = 1'b1;
    start2 = 1'b0; start3 = 1'b0; start_e = 1'b0; start4 = 1'b0;
    parity_in = 1'b0; shift_d = 1'b0; pv = 1'b0; pa = 1'b0;
    set_data(32'd0, 32'd0, 16'd0, 16'd0, 48'd0);
    tick();
    tick();
    rst = 1'b0; rst4 = 1'b0;
    tick();

    // reset state
    chk("rst_mtr", 32'(mtr[0]), NOP);
    chk("rst_ex", 32'(ex[0]), NOP);
    chk("rst_ovalid", 32'(ov[0]), 32'd0);
    chk("rst_oacc", 32'(oa[0]), 32'd0);
    chk("rst_busy", 32'(bsy[0]), 32'd0);
    chk("rst_done", 32'(dn[0]), 32'd0);
    chk("rst_serr", 32'(serr[0]), 32'd0);
    chk("rst_tcnt", tcnt[0], 32'd0);
    chk("rst_acnt", acnt[0], 32'd0);

    // T1/T2: ID=2 leader, parity 0; ten rounds, seven accepted
    parity_in = 1'b0;
    lead2("t1",   32'd10, 32'd4, 16'd3, 16'd1, 48'd0, 1'b1);
    lead2("t2a",  32'd4, 32'd10, 16'd3, 16'd1, -48'sd11, 1'b0);
    lead2("t2b",  32'd5, 32'd5, 16'd3, 16'd1, 48'd0, 1'b1);
    lead2("zero", 32'd1, 32'd1, 16'd0, 16'd0, 48'd0, 1'b1);
    lead2("edge0", 32'd20, 32'd0, 16'd5, 16'd0, -48'sd100, 1'b1);
    lead2("edgem1", 32'd20, 32'd0, 16'd5, 16'd0, -48'sd101, 1'b0);
    lead2("negneg", -32'sd7, 32'd3, -16'sd2, 16'd4, -48'sd59, 1'b1);
    lead2("negpos", -32'sd7, 32'd3, 16'd4, -16'sd2, 48'd0, 1'b0);
    lead2("wide", 32'h7FFF_FFFF, 32'h8000_0000, 16'h7FFF, 16'h8000, 48'd0, 1'b1);
    lead2("eq", 32'd100, 32'd100, 16'd0, 16'd0, 48'd0, 1'b1);
    chk("t6_trial", tcnt[0], EXP_TRIAL);
    chk("t6_accept", acnt[0], EXP_ACCEPT);

    // start in the done cycle is accepted
    set_data(32'd10, 32'd4, 16'd3, 16'd1, 48'd0);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    tick();
    tick();
    set_data(32'd4, 32'd10, 16'd3, 16'd1, -48'sd11);
    start2 = 1'b1;
    #1;
    chk("chain_done", 32'(dn[0]), 32'd1);
    tick();
    start2 = 1'b0;
    chk("chain_busy", 32'(bsy[0]), 32'd1);
    chk("chain_nop", 32'(mtr[0]), NOP);
    chk("chain_serr", 32'(serr[0]), 32'd0);
    tick();
    tick();
    chk("chain_done2", 32'(dn[0]), 32'd1);
    chk("chain_mtr", 32'(mtr[0]), SELF);
    chk("chain_oacc", 32'(oa[0]), 32'd0);
    tick();

    // T3: ID=3 follower; stray prev_valid while idle is ignored
    pv = 1'b1; pa = 1'b1;
    #1;
    chk("t3_idle_done", 32'(dn[1]), 32'd0);
    tick();
    pv = 1'b0; pa = 1'b0;
    chk("t3_idle_mtr", 32'(mtr[1]), NOP);
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    chk("t3_busy", 32'(bsy[1]), 32'd1);
    chk("t3_done1", 32'(dn[1]), 32'd0);
    chk("t3_ovalid", 32'(ov[1]), 32'd0);
    tick();
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    chk("t3_serr", 32'(serr[1]), 32'd1);
    chk("t3_busy3", 32'(bsy[1]), 32'd1);
    tick();
    tick();
    pv = 1'b1; pa = 1'b1;
    #1;
    chk("t3_done5", 32'(dn[1]), 32'd1);
    chk("t3_mtr", 32'(mtr[1]), PREV);
    tick();
    pv = 1'b0; pa = 1'b0;
    chk("t3_done6", 32'(dn[1]), 32'd0);
    chk("t3_idle", 32'(bsy[1]), 32'd0);
    chk("t3_hold", 32'(mtr[1]), PREV);

    // T4: ID=0 and ID=31 with parity 1 stand alone
    parity_in = 1'b1;
    start_e = 1'b1;
    tick();
    start_e = 1'b0;
    chk("t4_done0", 32'(dn[2]), 32'd1);
    chk("t4_done31", 32'(dn[3]), 32'd1);
    chk("t4_mtr0", 32'(mtr[2]), SELF);
    chk("t4_mtr31", 32'(mtr[3]), SELF);
    chk("t4_ov0", 32'(ov[2]), 32'd0);
    shift_d = 1'b1;
    #1;
    chk("t4_shift_ex", 32'(ex[2]), PREV);
    chk("t4_shift_mtr", 32'(mtr[2]), SELF);
    shift_d = 1'b0;
    #1;
    chk("t4_noshift_ex", 32'(ex[3]), SELF);
    tick();
    chk("t4_end0", 32'(dn[2]), 32'd0);
    chk("t4_end31", 32'(bsy[3]), 32'd0);

    // T5: ID=4 with auto parity; leader round first
    parity_in = 1'b0;
    set_data(32'd10, 32'd4, 16'd3, 16'd1, 48'd0);
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    tick();
    chk("t5_r1_done", 32'(dn[4]), 32'd1);
    chk("t5_r1_ov", 32'(ov[4]), 32'd1);
    chk("t5_r1_mtr", 32'(mtr[4]), FOLW);
    tick();
    // second round is a follower round
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    chk("t5_r2_nop", 32'(mtr[4]), NOP);
    tick();
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    chk("t5_r2_done3", 32'(dn[4]), 32'd0);
    chk("t5_r2_ov", 32'(ov[4]), 32'd0);
    chk("t5_r2_serr", 32'(serr[4]), 32'd1);
    pv = 1'b1; pa = 1'b0;
    #1;
    chk("t5_r2_done", 32'(dn[4]), 32'd1);
    chk("t5_r2_mtr", 32'(mtr[4]), SELF);
    tick();
    pv = 1'b0;
    chk("t5_r2_idle", 32'(bsy[4]), 32'd0);
    // third round (leader) reset in S2
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    rst4 = 1'b1;
    #1;
    chk("t5_rst_busy", 32'(bsy[4]), 32'd0);
    chk("t5_rst_done", 32'(dn[4]), 32'd0);
    chk("t5_rst_mtr", 32'(mtr[4]), NOP);
    chk("t5_rst_ex", 32'(ex[4]), NOP);
    chk("t5_rst_ov", 32'(ov[4]), 32'd0);
    chk("t5_rst_serr", 32'(serr[4]), 32'd0);
    tick();
    rst4 = 1'b0;
    tick();
    chk("t5_nodone", 32'(dn[4]), 32'd0);
    // parity restarts at 0, so the next round leads again
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    tick();
    chk("t5_r4_ov", 32'(ov[4]), 32'd1);
    chk("t5_r4_mtr", 32'(mtr[4]), FOLW);
    tick();

    chk("end_serr2", 32'(serr[0]), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
